fmul_arbiter: RTL and testbench

Round-robin arbiter and 2-stage pipeline that shares one `FMul` single-precision multiplier among `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block registers the granted operands and drives the combinational `FMul` from that register. It returns the registered product on a single response port, tagged with the requester index and held under backpressure.

---
 rtl/fmul_arbiter_if.sv | 26 ++
 rtl/fmul_arbiter.sv | 149 ++++++++++++++
 tb/tb_fmul_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmul_arbiter_if.sv
// Requester/response bundle shared between the requesters, the consumer and fmul_arbiter.
// Requesters and the consumer use the master side; the arbiter uses the slave side.
interface fmul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  resp_valid;
    logic [31:0]           resp_data;
    logic [ID_W-1:0]       resp_id;
    logic                  resp_ready;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id, busy
    );
endinterface

// File: rtl/fmul_arbiter.sv
// Round-robin arbiter feeding a shared single-precision multiplier through a
// two-stage pipeline (operand register S1, response register S2).

// Combinational IEEE-754 single multiply. Denormals flush to zero, the mantissa
// truncates, and overflow/underflow saturate to signed infinity/zero.
module FMul (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);
    logic        sign;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [24:0] prod_hi;
    logic [9:0]  esum;
    logic [22:0] frac;

    always_comb begin
        sign    = a[31] ^ b[31];
        a_zero  = (a[30:23] == 8'h00);
        b_zero  = (b[30:23] == 8'h00);
        a_inf   = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf   = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        prod_hi = 25'(({24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]}) >> 23);
        esum    = {2'b00, a[30:23]} + {2'b00, b[30:23]} + {9'd0, prod_hi[24]};
        frac    = prod_hi[24] ? prod_hi[23:1] : prod_hi[22:0];
        p       = {sign, 8'(esum - 10'd127), frac};

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            p = 32'h7F800001;
        end else if (a_inf || b_inf || esum >= 10'd382) begin
            p = {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero || esum <= 10'd127) begin
            p = {sign, 31'd0};
        end
    end
endmodule

module fmul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fmul_arbiter_if.slave bus
);
    logic                s1_valid_q, s1_valid_d;
    logic [ID_W-1:0]     s1_id_q, s1_id_d;
    logic [31:0]         s1_a_q, s1_a_d;
    logic [31:0]         s1_b_q, s1_b_d;
    logic                resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]     resp_id_q, resp_id_d;
    logic [31:0]         resp_data_q, resp_data_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic                out_stall, s1_adv, accept_ok, found, handshake;
    int                  scan_idx, grant_idx;
    logic [NUM_REQ-1:0]  req_ready;
    logic [31:0]         fmul_p;

    FMul u_fmul (
        .a (s1_a_q),
        .b (s1_b_q),
        .p (fmul_p)
    );

    // Grant search starts at rr_ptr and wraps; rst_n gating keeps req_ready low during reset.
    always_comb begin
        out_stall = resp_valid_q & ~bus.resp_ready;
        s1_adv    = s1_valid_q & ~out_stall;
        accept_ok = rst_n & (~s1_valid_q | ~out_stall);
        found     = 1'b0;
        grant_idx = 0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!found && bus.req_valid[scan_idx]) begin
                found     = 1'b1;
                grant_idx = scan_idx;
            end
        end
        handshake = found & accept_ok;
        req_ready = '0;
        if (handshake) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_id_d      = s1_id_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        rr_ptr_d     = rr_ptr_q;

        if (handshake) begin
            s1_valid_d = 1'b1;
            s1_id_d    = ID_W'(grant_idx);
            s1_a_d     = bus.req_a[32*grant_idx +: 32];
            s1_b_d     = bus.req_b[32*grant_idx +: 32];
            rr_ptr_d   = (grant_idx == NUM_REQ - 1) ? '0 : ID_W'(grant_idx + 1);
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            resp_valid_d = 1'b1;
            resp_id_d    = s1_id_q;
            resp_data_d  = fmul_p;
        end else if (resp_valid_q && bus.resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_id_q      <= '0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            rr_ptr_q     <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_id_q      <= s1_id_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.busy       = s1_valid_q | resp_valid_q;
endmodule

// File: tb/tb_fmul_arbiter.sv
// Self-checking bench for fmul_arbiter: directed vectors, corner sequences and
// random traffic compared against a queue-based reference model.
module tb_fmul_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fmul_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    fmul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        int          born;
    } entry_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
    } vec_t;

    entry_t      inflight[$];
    int          grant_log[$];
    int          resp_id_log[$];
    logic [31:0] resp_data_log[$];
    int          rr_model;
    int          edge_count;
    int          tests_run;
    int          tests_failed;

    // Reference multiply done in real arithmetic: the 48-bit exact product fits a double.
    function automatic logic [31:0] fmul_ref(logic [31:0] a, logic [31:0] b);
        logic        s;
        int          ea, eb, e, m;
        int unsigned ma, mb;
        real         x;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = a[22:0];
        mb = b[22:0];
        if ((ea == 255 && ma != 0) || (eb == 255 && mb != 0)) return 32'h7F800001;
        if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return 32'h7F800001;
        if (ea == 255 || eb == 255) return {s, 8'hFF, 23'd0};
        if (ea == 0 || eb == 0) return {s, 31'd0};
        x = (1.0 + real'(ma) / 8388608.0) * (1.0 + real'(mb) / 8388608.0);
        e = ea + eb - 127;
        if (x >= 2.0) begin
            x = x / 2.0;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        m = $rtoi((x - 1.0) * 8388608.0);
        return {s, 8'(e), 23'(m)};
    endfunction

    function automatic logic [31:0] rand_operand();
        int kind;
        logic [31:0] r;
        kind = int'($urandom_range(0, 9));
        r    = $urandom;
        case (kind)
            0: return {r[31], 31'd0};
            1: return {r[31], 8'hFF, 23'd0};
            2: return {r[31], (r[0] ? 8'($urandom_range(1, 10)) : 8'($urandom_range(245, 254))), r[22:0]};
            default: return {r[31], 8'($urandom_range(100, 154)), r[22:0]};
        endcase
    endfunction

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic set_req(int i, logic [31:0] a, logic [31:0] b);
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
    endtask

    // One clock of traffic: called at a falling edge with inputs already driven.
    task automatic applyStimulus();
        int g;
        logic found, acc, exp_rv, hs, cons;
        logic [NUM_REQ-1:0] exp_ready;
        entry_t e;
        #1;
        found = 1'b0;
        g = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (rr_model + k) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                g = idx;
            end
        end
        acc = !(inflight.size() == 2 && !bus.resp_ready);
        exp_ready = '0;
        if (found && acc) exp_ready[g] = 1'b1;
        exp_rv = (inflight.size() > 0) && (inflight[0].born < edge_count - 1);
        checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        checkOutput("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
        if (exp_rv) begin
            checkOutput("resp_data", bus.resp_data, fmul_ref(inflight[0].a, inflight[0].b));
            checkOutput("resp_id", 32'(bus.resp_id), 32'(inflight[0].id));
        end
        checkOutput("busy", 32'(bus.busy), 32'(inflight.size() > 0));
        hs   = found && acc;
        cons = exp_rv && bus.resp_ready;
        e.id   = g;
        e.a    = bus.req_a[32*g +: 32];
        e.b    = bus.req_b[32*g +: 32];
        e.born = edge_count;
        @(posedge clk);
        if (cons) begin
            resp_id_log.push_back(inflight[0].id);
            resp_data_log.push_back(fmul_ref(inflight[0].a, inflight[0].b));
            void'(inflight.pop_front());
        end
        if (hs) begin
            inflight.push_back(e);
            grant_log.push_back(g);
            rr_model = (g + 1) % NUM_REQ;
        end
        edge_count++;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(string tag);
        checkOutput({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        checkOutput({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        checkOutput({tag, "_resp_data"}, bus.resp_data, 32'd0);
        checkOutput({tag, "_resp_id"}, 32'(bus.resp_id), 32'd0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        bus.req_valid = '1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        bus.req_valid = '0;
        rst_n = 1'b1;
        inflight.delete();
        rr_model = 0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t vecs[13];
        tests_run    = 0;
        tests_failed = 0;
        rr_model     = 0;
        edge_count   = 0;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;

        vecs[0]  = {32'h40000000, 32'h40400000, 32'h40C00000};
        vecs[1]  = {32'h3FC00000, 32'h3FC00000, 32'h40100000};
        vecs[2]  = {32'h3FC00000, 32'hC0400000, 32'hC0900000};
        vecs[3]  = {32'h7F800000, 32'h40000000, 32'h7F800000};
        vecs[4]  = {32'h7F800000, 32'h00000000, 32'h7F800001};
        vecs[5]  = {32'hFF800000, 32'h40000000, 32'hFF800000};
        vecs[6]  = {32'h80000000, 32'h40A00000, 32'h80000000};
        vecs[7]  = {32'h7F000000, 32'h7F000000, 32'h7F800000};
        vecs[8]  = {32'h00800000, 32'h00800000, 32'h00000000};
        vecs[9]  = {32'h7FC00000, 32'h3F800000, 32'h7F800001};
        vecs[10] = {32'h3F800000, 32'hBF800000, 32'hBF800000};
        vecs[11] = {32'h00000001, 32'h40000000, 32'h00000000};
        vecs[12] = {32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE};

        doReset();

        // Single requester 1: 2.0 * 3.0 returns after two edges.
        set_req(1, 32'h40000000, 32'h40400000);
        bus.req_valid = 4'b0010;
        applyStimulus();
        bus.req_valid = 4'b0000;
        applyStimulus();
        checkOutput("single_valid", 32'(bus.resp_valid), 32'd1);
        checkOutput("single_data", bus.resp_data, 32'h40C00000);
        checkOutput("single_id", 32'(bus.resp_id), 32'd1);
        applyStimulus();

        // All four requesters continuously valid: strict rotation from 0.
        doReset();
        grant_log.delete();
        resp_id_log.delete();
        resp_data_log.delete();
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, 32'h3FC00000, (i % 2 == 1) ? 32'hC0400000 : 32'h3FC00000);
        end
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) applyStimulus();
        bus.req_valid = 4'b0000;
        for (int c = 0; c < 3; c++) applyStimulus();
        checkOutput("rr_grant_count", 32'(grant_log.size()), 32'd8);
        checkOutput("rr_resp_count", 32'(resp_id_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < grant_log.size()) checkOutput("rr_grant", 32'(grant_log[i]), 32'(i % 4));
            if (i < resp_id_log.size()) begin
                checkOutput("rr_resp_id", 32'(resp_id_log[i]), 32'(i % 4));
                checkOutput("rr_resp_data", resp_data_log[i],
                            (i % 2 == 1) ? 32'hC0900000 : 32'h40100000);
            end
        end

        // Backpressure with requesters 0 and 2: S1 fills, then everything freezes.
        resp_id_log.delete();
        set_req(0, 32'h40000000, 32'h40400000);
        set_req(2, 32'h3FC00000, 32'hC0400000);
        bus.req_valid  = 4'b0101;
        bus.resp_ready = 1'b1;
        applyStimulus();
        bus.resp_ready = 1'b0;
        applyStimulus();
        for (int c = 0; c < 4; c++) begin
            checkOutput("stall_valid", 32'(bus.resp_valid), 32'd1);
            checkOutput("stall_data", bus.resp_data, 32'h40C00000);
            checkOutput("stall_id", 32'(bus.resp_id), 32'd0);
            applyStimulus();
        end
        #1 checkOutput("stall_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        bus.req_valid  = 4'b0000;
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 3; c++) applyStimulus();
        checkOutput("drain_count", 32'(resp_id_log.size()), 32'd2);
        if (resp_id_log.size() == 2) begin
            checkOutput("drain_first", 32'(resp_id_log[0]), 32'd0);
            checkOutput("drain_second", 32'(resp_id_log[1]), 32'd2);
        end

        // Table of operand pairs through requester 3, including special encodings.
        for (int v = 0; v < 13; v++) begin
            set_req(3, vecs[v].a, vecs[v].b);
            bus.req_valid = 4'b1000;
            applyStimulus();
            bus.req_valid = 4'b0000;
            applyStimulus();
            checkOutput("vec_valid", 32'(bus.resp_valid), 32'd1);
            checkOutput($sformatf("vec%0d_data", v), bus.resp_data, vecs[v].p);
            applyStimulus();
        end

        // Reset one cycle after a handshake: the pending response is dropped.
        set_req(2, 32'h40000000, 32'h40000000);
        bus.req_valid = 4'b0100;
        applyStimulus();
        bus.req_valid = 4'b0000;
        applyStimulus();
        checkOutput("midrst_pre_valid", 32'(bus.resp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        inflight.delete();
        rr_model = 0;
        applyStimulus();
        applyStimulus();
        bus.req_valid = 4'b1111;
        #1 checkOutput("midrst_first_grant", 32'(bus.req_ready), 32'b0001);
        applyStimulus();
        bus.req_valid = 4'b0000;
        for (int c = 0; c < 3; c++) applyStimulus();

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) set_req(i, rand_operand(), rand_operand());
            bus.req_valid  = NUM_REQ'($urandom_range(0, 15));
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            applyStimulus();
        end
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 4; c++) applyStimulus();
        checkOutput("final_idle", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
